// File: rtl/data_memory_ctrl_if.sv
// Access bus for data_memory_ctrl.
//   master (requester): drives req, we, address, data, byte_en, clear_req;
//                       receives ready, data_out, rvalid, err, busy.
//   slave  (memory)   : the mirror image.
interface data_memory_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     data;
  logic [DATA_W/8-1:0]   byte_en;
  logic                  clear_req;
  logic                  ready;
  logic [DATA_W-1:0]     data_out;
  logic                  rvalid;
  logic                  err;
  logic                  busy;

  modport master (
    output req, we, address, data, byte_en, clear_req,
    input  ready, data_out, rvalid, err, busy
  );

  modport slave (
    input  req, we, address, data, byte_en, clear_req,
    output ready, data_out, rvalid, err, busy
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: word-addressed data memory with byte-lane writes,
// 1-cycle registered reads, out-of-range error flagging and a full
// zero-clear sweep that runs after reset and on clear_req.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : data_memory_ctrl_if.slave (req/we/address/data/byte_en/
//           clear_req in; ready/data_out/rvalid/err/busy out)
module data_memory_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                clk,
  input  logic                reset,
  data_memory_ctrl_if.slave   bus
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   cnt, cnt_nx;
  logic               ready, busy;
  logic               accept;
  logic               in_range;
  logic [IDX_W-1:0]   idx;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  data_out_q;
  logic               rvalid_q;
  logic               err_q;

  // Extra top bit lets DEPTH == 2**ADDR_W compare correctly.
  assign in_range = ({1'b0, bus.address} < (ADDR_W + 1)'(DEPTH));
  assign idx      = bus.address[IDX_W-1:0];
  assign accept   = bus.req & ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready    = 1'b0;
    busy     = 1'b0;
    case (state)
      CLEAR: begin
        busy   = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      IDLE: begin
        ready = 1'b1;
        if (bus.clear_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  // Storage has no reset; its contents are defined only by the sweep.
  // Sweep and accepted writes are mutually exclusive since accept needs IDLE.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (accept && bus.we && in_range) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (bus.byte_en[i]) begin
          mem[idx][8*i +: 8] <= bus.data[8*i +: 8];
        end
      end
    end
  end

  // Response stage: rvalid/err are single-cycle pulses, data_out holds
  // its value unless a read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (accept) begin
        err_q <= ~in_range;
        if (!bus.we) begin
          rvalid_q   <= 1'b1;
          data_out_q <= in_range ? mem[idx] : '0;
        end
      end
    end
  end

  assign bus.ready    = ready;
  assign bus.busy     = busy;
  assign bus.data_out = data_out_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  logic clk;
  logic reset;
  int   nerr;
  int   nchk;

  data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  data_memory_ctrl #(
    .DATA_W(32),
    .ADDR_W(8),
    .DEPTH (64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one access and return 1 time unit after the accepting edge.
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    bus.req     = 1'b1;
    bus.we      = w;
    bus.address = a;
    bus.data    = d;
    bus.byte_en = be;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles while busy, bounded so a stuck sweep still terminates.
  task automatic count_busy(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  int cycles;
  int stray;

  initial begin
    nerr = 0;
    nchk = 0;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.address   = '0;
    bus.data      = '0;
    bus.byte_en   = '0;
    bus.clear_req = 1'b0;
    reset         = 1'b1;

    #2;
    check("rst_ready",  32'(bus.ready),  32'd0);
    check("rst_busy",   32'(bus.busy),   32'd1);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_err",    32'(bus.err),    32'd0);
    check("rst_dout",   bus.data_out,    32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    count_busy(cycles);
    check("post_rst_sweep_len", 32'(cycles), 32'd64);
    check("post_rst_ready", 32'(bus.ready), 32'd1);

    // Every word reads zero after the sweep; back-to-back reads.
    for (int a = 0; a < 64; a++) begin
      issue(1'b0, 8'(a), 32'h0, 4'h0);
      check("sweep_zero", bus.data_out, 32'h0);
      check("sweep_rvalid", 32'(bus.rvalid), 32'd1);
    end
    idle_cycle();
    check("rvalid_drop", 32'(bus.rvalid), 32'd0);

    // Byte-lane merge.
    issue(1'b1, 8'd5, 32'hDEADBEEF, 4'b1111);
    check("wr_no_rvalid", 32'(bus.rvalid), 32'd0);
    check("wr_no_err",    32'(bus.err),    32'd0);
    issue(1'b1, 8'd5, 32'h00AA0000, 4'b0100);
    issue(1'b0, 8'd5, 32'h0, 4'h0);
    check("lane_merge", bus.data_out, 32'hDEAABEEF);
    check("lane_rvalid", 32'(bus.rvalid), 32'd1);
    idle_cycle();
    check("dout_hold", bus.data_out, 32'hDEAABEEF);
    check("hold_rvalid", 32'(bus.rvalid), 32'd0);

    // Read right after write to same address.
    issue(1'b1, 8'd3, 32'h12345678, 4'b1111);
    issue(1'b0, 8'd3, 32'h0, 4'h0);
    check("raw_b2b", bus.data_out, 32'h12345678);

    // Zero byte_en write changes nothing and flags nothing.
    issue(1'b1, 8'd3, 32'hFFFFFFFF, 4'b0000);
    check("be0_err", 32'(bus.err), 32'd0);
    issue(1'b0, 8'd3, 32'h0, 4'h0);
    check("be0_unchanged", bus.data_out, 32'h12345678);

    // Consecutive reads of different words.
    issue(1'b0, 8'd5, 32'h0, 4'h0);
    check("b2b_rd0", bus.data_out, 32'hDEAABEEF);
    issue(1'b0, 8'd3, 32'h0, 4'h0);
    check("b2b_rd1", bus.data_out, 32'h12345678);
    check("b2b_rvalid1", 32'(bus.rvalid), 32'd1);

    // Request with req low is ignored.
    bus.we = 1'b1; bus.address = 8'd5; bus.data = 32'h11111111; bus.byte_en = 4'hF;
    idle_cycle();
    issue(1'b0, 8'd5, 32'h0, 4'h0);
    check("noreq_ignored", bus.data_out, 32'hDEAABEEF);

    // Out-of-range write and read (200 aliases word 8 in the low bits).
    issue(1'b1, 8'd200, 32'hA5A5A5A5, 4'hF);
    check("oor_wr_err",    32'(bus.err),    32'd1);
    check("oor_wr_rvalid", 32'(bus.rvalid), 32'd0);
    check("oor_wr_dout_hold", bus.data_out, 32'hDEAABEEF);
    issue(1'b0, 8'd200, 32'h0, 4'h0);
    check("oor_rd_dout",   bus.data_out,    32'h0);
    check("oor_rd_rvalid", 32'(bus.rvalid), 32'd1);
    check("oor_rd_err",    32'(bus.err),    32'd1);
    idle_cycle();
    check("oor_err_pulse", 32'(bus.err), 32'd0);
    issue(1'b0, 8'd8, 32'h0, 4'h0);
    check("oor_no_alias", bus.data_out, 32'h0);
    check("inrange_no_err", 32'(bus.err), 32'd0);

    // Boundary: 63 in range, 64 out of range.
    issue(1'b1, 8'd63, 32'h0BADCAFE, 4'hF);
    check("wr63_err", 32'(bus.err), 32'd0);
    issue(1'b1, 8'd64, 32'h77777777, 4'hF);
    check("wr64_err", 32'(bus.err), 32'd1);
    issue(1'b0, 8'd63, 32'h0, 4'h0);
    check("rd63", bus.data_out, 32'h0BADCAFE);
    issue(1'b0, 8'd0, 32'h0, 4'h0);
    check("rd0_no_alias", bus.data_out, 32'h0);

    // Clear request together with a read: read completes with old data.
    issue(1'b1, 8'd10, 32'hCAFEF00D, 4'hF);
    bus.clear_req = 1'b1;
    issue(1'b0, 8'd10, 32'h0, 4'h0);
    bus.clear_req = 1'b0;
    check("clr_rd_old", bus.data_out, 32'hCAFEF00D);
    check("clr_rd_rvalid", 32'(bus.rvalid), 32'd1);
    check("clr_busy", 32'(bus.busy), 32'd1);
    check("clr_not_ready", 32'(bus.ready), 32'd0);
    // During the sweep: a second clear_req and a write to word 0 (already
    // cleared) must both be ignored, and no rvalid/err may appear.
    cycles = 0;
    stray  = 0;
    while (bus.busy && cycles < 200) begin
      bus.clear_req = (cycles == 10);
      if (cycles == 20) begin
        bus.req = 1'b1; bus.we = 1'b1; bus.address = 8'd0;
        bus.data = 32'hFFFFFFFF; bus.byte_en = 4'hF;
      end else begin
        bus.req = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (bus.rvalid || bus.err) stray++;
    end
    bus.req = 1'b0;
    bus.clear_req = 1'b0;
    check("clr_sweep_len", 32'(cycles), 32'd64);
    check("clr_no_stray", 32'(stray), 32'd0);
    check("clr_dout_hold", bus.data_out, 32'hCAFEF00D);
    issue(1'b0, 8'd10, 32'h0, 4'h0);
    check("clr_rd_zero", bus.data_out, 32'h0);
    issue(1'b0, 8'd0, 32'h0, 4'h0);
    check("clr_wr_ignored", bus.data_out, 32'h0);

    // Reset right after a read is accepted: pulse and data are dropped.
    issue(1'b1, 8'd7, 32'h13572468, 4'hF);
    issue(1'b0, 8'd7, 32'h0, 4'h0);
    check("pre_rst_rd", bus.data_out, 32'h13572468);
    reset = 1'b1;
    #1;
    check("arst_rvalid", 32'(bus.rvalid), 32'd0);
    check("arst_dout",   bus.data_out,    32'h0);
    check("arst_busy",   32'(bus.busy),   32'd1);
    check("arst_ready",  32'(bus.ready),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_busy(cycles);
    check("arst_sweep_len", 32'(cycles), 32'd64);

    // Reset at cycle 30 of a sweep restarts a full sweep.
    bus.clear_req = 1'b1;
    idle_cycle();
    bus.clear_req = 1'b0;
    repeat (30) idle_cycle();
    check("mid_sweep_busy", 32'(bus.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy",  32'(bus.busy),  32'd1);
    check("mid_rst_ready", 32'(bus.ready), 32'd0);
    check("mid_rst_err",   32'(bus.err),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_busy(cycles);
    check("mid_rst_sweep_len", 32'(cycles), 32'd64);
    check("mid_rst_ready_end", 32'(bus.ready), 32'd1);
    issue(1'b0, 8'd7, 32'h0, 4'h0);
    check("mid_rst_rd_zero", bus.data_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
